iic_dri_16b: RTL and testbench
==============================

// Module: iic_dri_16b
// PURPOSE
//   I2C master engine executing single-byte register transactions with 16-bit register address,
//   the responder to the display-chip control FSMs (e.g. MS7210 init sequencer).
//   Accepts one command (trig, w_r, addr, data_in) and returns busy/byte_over/data_out.
//   Drives SCL and open-drain SDA to the board pins.
// PARAMETERS
//   CLK_FREQ  50_000_000  system clock frequency, Hz
//   SCL_FREQ  100_000     SCL bit rate, Hz; QDIV = CLK_FREQ/(4*SCL_FREQ) clk cycles per quarter-bit, QDIV >= 2
// PORTS
//   clk        in   1   system clock
//   rstn       in   1   asynchronous active-low reset
//   device_id  in   8   7-bit slave address in [7:1]; bit0 ignored, replaced by R/W bit
//   iic_trig   in   1   start request, sampled only while busy==0
//   w_r        in   1   1 = write, 0 = read; latched with iic_trig
//   addr       in   16  register address, sent MSB byte first; latched with iic_trig
//   data_in    in   8   write data; latched with iic_trig
//   busy       out  1   high from the cycle after trig acceptance until the STOP slot completes
//   data_out   out  8   last byte read; updated at the read byte's NACK slot, held otherwise
//   byte_over  out  1   one-cycle pulse per successful transaction at end of its data-byte ACK/NACK slot
//   ack_err    out  1   slave NACK seen in current/last transaction; cleared on next accepted trig
//   scl        out  1   SCL, push-pull
//   sda_oe     out  1   1 = pull SDA low, 0 = release (pull-up gives 1)
//   sda_in     in   1   SDA pin level (synchronised internally with 2 flops)
// BEHAVIOUR
//   Reset (async, any time, incl. mid-transaction): busy=0, byte_over=0, ack_err=0, data_out=8'h00,
//     scl=1, sda_oe=0; FSM to IDLE; bus released within the reset assertion, no STOP generated.
//   Timing: quarter counter ticks every QDIV clks; each slot = 4 quarters (q0..q3) = 4*QDIV clks.
//     bit slot: q0 SCL0 SDA=bit; q1,q2 SCL1; sample sda_in at q2 entry; q3 SCL0. SDA changes only with SCL low.
//     START/RSTART slot: q0 SCL0 SDA1; q1 SCL1 SDA1; q2 SCL1 SDA0; q3 SCL0 SDA0.
//     STOP slot: q0 SCL0 SDA0; q1 SCL1 SDA0; q2,q3 SCL1 SDA1.
//   FSM: IDLE -> START -> TX_BYTE <-> ACK_CHK -> (RSTART -> TX_BYTE -> ACK_CHK -> RX_BYTE -> MNACK) -> STOP -> IDLE.
//   Write (w_r=1): START, {dev[7:1],0}, A, addr[15:8], A, addr[7:0], A, data_in, A, STOP = 38 slots.
//   Read  (w_r=0): START, {dev[7:1],0}, A, addr[15:8], A, addr[7:0], A, RSTART, {dev[7:1],1}, A,
//     8 RX bits MSB first, master NACK (SDA released), STOP = 48 slots.
//   busy high exactly slots*4*QDIV clks for a successful transaction; rises cycle after trig accepted.
//   iic_trig while busy==1: ignored, no latch. Trig in cycle busy is 0 (e.g. right after falling edge): accepted.
//   byte_over: pulses in last clk of data-byte ACK slot (write) or MNACK slot (read); data_out valid same cycle.
//   Slave NACK in any ACK_CHK: ack_err=1, remaining bytes skipped, go to STOP next slot, busy falls after
//     STOP, byte_over NOT pulsed, data_out unchanged.
//   TX bits: shift register loaded at slot start, MSB first; sda_oe = ~bit. ACK slot: sda_oe=0.
// TESTING
//   Write dev 8'hB2, addr 16'h1281, data 8'h04, slave ACKs all -> SDA bytes B2,12,81,04; busy 38*4*QDIV clks; 1 byte_over; ack_err=0.
//   Read dev 8'hB2, addr 16'h0003, slave returns 8'h5A -> bytes B2,00,03,RSTART,B3; data_out=8'h5A at byte_over; master NACK; 48 slots.
//   Slave NACKs addr[15:8] byte -> STOP follows, ack_err=1, no byte_over, busy falls; next trig clears ack_err.
//   iic_trig pulsed mid-transaction with different addr -> ignored, bus sequence unchanged.
//   rstn low during 3rd byte -> scl=1, sda_oe=0, busy=0 immediately; next trig runs a clean transaction.
//   Back-to-back: trig one cycle after busy falls (sequencer style, 20 writes) -> 20 byte_over pulses, no lost command.

Source files
------------

// File: rtl/iic_dri_16b.sv
// iic_dri_16b: I2C master for single-byte register write/read with a 16-bit register address
module iic_dri_16b #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCL_FREQ = 100_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  device_id,
  input  logic        iic_trig,
  input  logic        w_r,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [7:0]  data_out,
  output logic        byte_over,
  output logic        ack_err,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_in
);
  localparam int QDIV = CLK_FREQ / (4 * SCL_FREQ);
  localparam int QW = $clog2(QDIV);
  typedef enum logic [2:0] {IDLE, START, TX_BYTE, ACK_CHK, RSTART, RX_BYTE, MNACK, STOP} state_t;
  state_t state, state_nx;
  logic [QW-1:0] qcnt;
  logic [1:0] q, byte_cnt, sda_s;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sh, rx_sh, dev_l, data_l;
  logic [15:0] addr_l;
  logic wr_l, ack_bit, q_end, slot_end, samp;
  assign q_end = qcnt == QW'(QDIV - 1);
  assign slot_end = q_end && q == 2'd3;
  assign samp = q_end && q == 2'd1;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = iic_trig ? START : IDLE;
    else if (slot_end)
      case (state)
        START, RSTART: state_nx = TX_BYTE;
        TX_BYTE: state_nx = bit_cnt == 3'd7 ? ACK_CHK : TX_BYTE;
        ACK_CHK: state_nx = ack_bit ? STOP :
                            byte_cnt != 2'd3 ? ((byte_cnt == 2'd2 && !wr_l) ? RSTART : TX_BYTE) :
                            wr_l ? STOP : RX_BYTE;
        RX_BYTE: state_nx = bit_cnt == 3'd7 ? MNACK : RX_BYTE;
        MNACK: state_nx = STOP;
        default: state_nx = IDLE;
      endcase
  end
  // SCL is high in q1/q2 of every slot except STOP, which parks it high from q1 on
  always_comb begin
    scl = state == IDLE ? 1'b1 : state == STOP ? q != 2'd0 : q[0] ^ q[1];
    sda_oe = (state == START || state == RSTART) ? q[1] :
             state == TX_BYTE ? ~tx_sh[7] :
             state == STOP ? ~q[1] : 1'b0;
    byte_over = slot_end && ((state == ACK_CHK && byte_cnt == 2'd3 && wr_l && !ack_bit) || state == MNACK);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      qcnt <= '0;
      q <= '0;
      byte_cnt <= '0;
      bit_cnt <= '0;
      sda_s <= 2'b11;
      tx_sh <= '0;
      rx_sh <= '0;
      dev_l <= '0;
      data_l <= '0;
      addr_l <= '0;
      wr_l <= 1'b0;
      ack_bit <= 1'b0;
      ack_err <= 1'b0;
      data_out <= '0;
    end else begin
      sda_s <= {sda_s[0], sda_in};
      if (state == IDLE) begin
        qcnt <= '0;
        q <= '0;
        if (iic_trig) begin
          dev_l <= device_id;
          wr_l <= w_r;
          addr_l <= addr;
          data_l <= data_in;
          ack_err <= 1'b0;
        end
      end else begin
        qcnt <= q_end ? '0 : qcnt + 1'b1;
        if (q_end) q <= q + 2'd1;
        if (samp) begin
          ack_bit <= sda_s[1];
          if (state == RX_BYTE) rx_sh <= {rx_sh[6:0], sda_s[1]};
        end
        if (slot_end)
          case (state)
            START: begin
              tx_sh <= dev_l & 8'hFE;
              byte_cnt <= 2'd0;
              bit_cnt <= 3'd0;
            end
            RSTART: begin
              tx_sh <= dev_l | 8'h01;
              byte_cnt <= 2'd3;
              bit_cnt <= 3'd0;
            end
            TX_BYTE: begin
              tx_sh <= tx_sh << 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
            RX_BYTE: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) data_out <= rx_sh;
            end
            ACK_CHK:
              if (ack_bit) ack_err <= 1'b1;
              else begin
                byte_cnt <= byte_cnt + 2'd1;
                tx_sh <= byte_cnt == 2'd0 ? addr_l[15:8] : byte_cnt == 2'd1 ? addr_l[7:0] : data_l;
              end
            default: ;
          endcase
      end
    end
endmodule

// File: tb/tb_iic_dri_16b.sv
// tb_iic_dri_16b: directed bench with a behavioural I2C slave and bus recorder
module tb_iic_dri_16b;
  logic clk = 1'b0, rstn = 1'b0, iic_trig = 1'b0, w_r = 1'b0;
  logic [7:0] device_id = 8'hB2, data_in = 8'h00;
  logic [15:0] addr = 16'h0000;
  logic busy, byte_over, ack_err, scl, sda_oe, sda_in;
  logic [7:0] data_out;
  logic slv_pull = 1'b0;
  logic [7:0] rd_data = 8'h5A;
  int nack_at = -1;
  logic [7:0] log_q[$];
  logic ack_q[$];
  int starts = 0, stops = 0, busy_total = 0, bo_total = 0;
  logic [7:0] bo_data = 8'h00;
  int bitcnt = 0, byte_no = 0;
  logic rd_mode = 1'b0, first = 1'b0, pscl = 1'b1, psda = 1'b1;
  logic [7:0] cur = 8'h00;
  int total = 0, passed = 0;
  int lb, bb, ob, sb, pb, n;

  assign sda_in = ~(sda_oe | slv_pull);

  iic_dri_16b #(.CLK_FREQ(800), .SCL_FREQ(100)) dut (
    .clk(clk), .rstn(rstn), .device_id(device_id), .iic_trig(iic_trig), .w_r(w_r),
    .addr(addr), .data_in(data_in), .busy(busy), .data_out(data_out), .byte_over(byte_over),
    .ack_err(ack_err), .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  // slave: ACKs every byte except nack_at, returns rd_data after an address byte with R=1
  always @(negedge clk) begin
    if (busy) busy_total++;
    if (byte_over) begin
      bo_total++;
      bo_data = data_out;
    end
    if (!rstn) begin
      bitcnt = 0;
      byte_no = 0;
      rd_mode = 1'b0;
      first = 1'b0;
      slv_pull = 1'b0;
    end else if (scl && pscl) begin
      if (psda && !sda_in) begin
        starts++;
        bitcnt = 0;
        first = 1'b1;
      end else if (!psda && sda_in) begin
        stops++;
        bitcnt = 0;
        byte_no = 0;
        rd_mode = 1'b0;
        slv_pull = 1'b0;
      end
    end else if (scl && !pscl) begin
      if (bitcnt < 8) cur = {cur[6:0], sda_in};
      else if (bitcnt == 8) begin
        log_q.push_back(cur);
        ack_q.push_back(sda_in);
      end
      bitcnt++;
    end else if (!scl && pscl) begin
      if (bitcnt == 8) slv_pull = rd_mode ? 1'b0 : (byte_no != nack_at);
      else if (bitcnt == 9) begin
        bitcnt = 0;
        byte_no++;
        if (!rd_mode && first && cur[0]) begin
          rd_mode = 1'b1;
          slv_pull = ~rd_data[7];
        end else begin
          rd_mode = 1'b0;
          slv_pull = 1'b0;
        end
        first = 1'b0;
      end else if (rd_mode) slv_pull = ~rd_data[7-bitcnt];
    end
    pscl = scl;
    psda = sda_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_trig(input logic wr, input logic [15:0] a, input logic [7:0] d);
    w_r = wr;
    addr = a;
    data_in = d;
    iic_trig = 1'b1;
    @(negedge clk);
    iic_trig = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic snap();
    lb = log_q.size();
    bb = busy_total;
    ob = bo_total;
    sb = starts;
    pb = stops;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_byte_over", 32'(byte_over), 0);
    chk("rst_ack_err", 32'(ack_err), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_scl", 32'(scl), 1);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    // plain write
    snap();
    do_trig(1'b1, 16'h1281, 8'h04);
    chk("wr_busy_rise", 32'(busy), 1);
    wait_idle("wr_idle");
    chk("wr_nbytes", log_q.size() - lb, 4);
    chk("wr_b0", 32'(log_q[lb]), 32'hB2);
    chk("wr_b1", 32'(log_q[lb+1]), 32'h12);
    chk("wr_b2", 32'(log_q[lb+2]), 32'h81);
    chk("wr_b3", 32'(log_q[lb+3]), 32'h04);
    chk("wr_acks", 32'({ack_q[lb], ack_q[lb+1], ack_q[lb+2], ack_q[lb+3]}), 0);
    chk("wr_busy_clks", busy_total - bb, 304);
    chk("wr_byte_over", bo_total - ob, 1);
    chk("wr_ack_err", 32'(ack_err), 0);
    chk("wr_starts", starts - sb, 1);
    chk("wr_stops", stops - pb, 1);
    // read with repeated start
    snap();
    do_trig(1'b0, 16'h0003, 8'hEE);
    wait_idle("rd_idle");
    chk("rd_nbytes", log_q.size() - lb, 5);
    chk("rd_b0", 32'(log_q[lb]), 32'hB2);
    chk("rd_b1", 32'(log_q[lb+1]), 32'h00);
    chk("rd_b2", 32'(log_q[lb+2]), 32'h03);
    chk("rd_b3", 32'(log_q[lb+3]), 32'hB3);
    chk("rd_b4", 32'(log_q[lb+4]), 32'h5A);
    chk("rd_master_nack", 32'(ack_q[lb+4]), 1);
    chk("rd_starts", starts - sb, 2);
    chk("rd_stops", stops - pb, 1);
    chk("rd_busy_clks", busy_total - bb, 384);
    chk("rd_byte_over", bo_total - ob, 1);
    chk("rd_bo_data", 32'(bo_data), 32'h5A);
    chk("rd_data_out", 32'(data_out), 32'h5A);
    // slave NACKs the high address byte
    nack_at = 1;
    snap();
    do_trig(1'b1, 16'h1281, 8'h04);
    wait_idle("nack_idle");
    chk("nack_nbytes", log_q.size() - lb, 2);
    chk("nack_ack1", 32'(ack_q[lb+1]), 1);
    chk("nack_ack_err", 32'(ack_err), 1);
    chk("nack_byte_over", bo_total - ob, 0);
    chk("nack_busy_clks", busy_total - bb, 160);
    chk("nack_stops", stops - pb, 1);
    chk("nack_data_out", 32'(data_out), 32'h5A);
    nack_at = -1;
    snap();
    do_trig(1'b1, 16'h2233, 8'h44);
    chk("ack_err_cleared", 32'(ack_err), 0);
    wait_idle("clr_idle");
    chk("clr_byte_over", bo_total - ob, 1);
    // trigger mid-transaction must be ignored
    snap();
    do_trig(1'b1, 16'h1281, 8'h04);
    repeat (50) @(negedge clk);
    do_trig(1'b0, 16'hFFFF, 8'hFF);
    wait_idle("ign_idle");
    chk("ign_nbytes", log_q.size() - lb, 4);
    chk("ign_b1", 32'(log_q[lb+1]), 32'h12);
    chk("ign_b2", 32'(log_q[lb+2]), 32'h81);
    chk("ign_b3", 32'(log_q[lb+3]), 32'h04);
    chk("ign_busy_clks", busy_total - bb, 304);
    chk("ign_starts", starts - sb, 1);
    // reset during the third byte
    snap();
    do_trig(1'b1, 16'h1281, 8'h04);
    n = 0;
    while (log_q.size() < lb + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached", 32'(log_q.size() - lb), 2);
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_scl", 32'(scl), 1);
    chk("rst_mid_sda_oe", 32'(sda_oe), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    do_trig(1'b1, 16'hABCD, 8'h77);
    wait_idle("post_rst_idle");
    chk("post_rst_nbytes", log_q.size() - lb, 4);
    chk("post_rst_b1", 32'(log_q[lb+1]), 32'hAB);
    chk("post_rst_b2", 32'(log_q[lb+2]), 32'hCD);
    chk("post_rst_b3", 32'(log_q[lb+3]), 32'h77);
    chk("post_rst_byte_over", bo_total - ob, 1);
    chk("post_rst_busy_clks", busy_total - bb, 304);
    // back-to-back writes, each triggered in the first idle cycle
    snap();
    for (int i = 0; i < 20; i++) begin
      do_trig(1'b1, 16'h1000 + 16'(i), 8'(i * 3));
      wait_idle("b2b_idle");
    end
    chk("b2b_byte_over", bo_total - ob, 20);
    chk("b2b_nbytes", log_q.size() - lb, 80);
    chk("b2b_busy_clks", busy_total - bb, 20 * 304);
    for (int i = 0; i < 20; i++) begin
      chk("b2b_addr_lo", 32'(log_q[lb + 4*i + 2]), 32'(i));
      chk("b2b_data", 32'(log_q[lb + 4*i + 3]), 32'(8'(i * 3)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
